// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: pulses pll_areset, qualifies lock, then releases sys_rst.
// Define LOCK_LOSS_COUNT_EN to add the saturating lock_loss_cnt output.
module pll_lock_sequencer #(
    parameter int unsigned ARST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       CPUCLK_I,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_areset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
`ifdef LOCK_LOSS_COUNT_EN
    output logic [7:0] lock_loss_cnt,
`endif
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ARST_LAST    = CNT_W'(ARST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       retry_nx;
    logic             sync1, locked_s;

    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        case (state)
            S_RESET_PLL: if (cnt == ARST_LAST) state_nx = S_WAIT_LOCK;
            // Lock wins over a timeout expiring in the same cycle.
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_nx = S_FAIL;
                    end else begin
                        state_nx = S_RESET_PLL;
                        retry_nx = retry_cnt + 4'd1;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s)                 state_nx = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST)   state_nx = S_RUN;
            end
            S_RUN:   if (!locked_s) state_nx = S_RESET_PLL;
            S_FAIL:  state_nx = S_FAIL;
            default: state_nx = S_RESET_PLL;
        endcase

        if (state_nx == S_RUN) retry_nx = '0;

        if (restart) begin
            state_nx = S_RESET_PLL;
            retry_nx = '0;
        end

        // Counter only runs in the timed states, so it can never wrap.
        if (restart || state_nx != state)
            cnt_nx = '0;
        else if (state == S_RESET_PLL || state == S_WAIT_LOCK || state == S_STABLE)
            cnt_nx = cnt + 1'b1;
        else
            cnt_nx = cnt;
    end

    always_ff @(posedge CPUCLK_I or posedge rst) begin
        if (rst) begin
            state      <= S_RESET_PLL;
            cnt        <= '0;
            retry_cnt  <= '0;
            sync1      <= 1'b0;
            locked_s   <= 1'b0;
            pll_areset <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
            state_o    <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            retry_cnt  <= retry_nx;
            sync1      <= pll_locked;
            locked_s   <= sync1;
            pll_areset <= (state_nx == S_RESET_PLL) || (state_nx == S_FAIL);
            sys_rst    <= (state_nx != S_RUN);
            ready      <= (state_nx == S_RUN);
            fail       <= (state_nx == S_FAIL);
            state_o    <= 3'(state_nx);
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic lock_lost;

    // A restart in the same cycle takes priority, so that exit is not a lock loss.
    always_comb lock_lost = (state == S_RUN) && !locked_s && !restart;

    always_ff @(posedge CPUCLK_I or posedge rst) begin
        if (rst)
            lock_loss_cnt <= '0;
        else if (lock_lost && lock_loss_cnt != '1)
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: phase/dwell timing model checked every cycle,
// plus hand-computed latency and count expectations from the test plan.
module tb_pll_lock_sequencer;

    localparam int ARST   = 4;
    localparam int TMO    = 20;
    localparam int STAB   = 8;
    localparam int MAXR   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       restart;
    logic       pll_areset, sys_rst, ready, fail;
    logic [3:0] retry_cnt;
    logic [2:0] state_o;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .ARST_CYCLES  (ARST),
        .LOCK_TIMEOUT (TMO),
        .STABLE_CYCLES(STAB),
        .MAX_RETRY    (MAXR),
        .CNT_W        (16)
    ) dut (
        .CPUCLK_I     (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .restart      (restart),
        .pll_areset   (pll_areset),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
`ifdef LOCK_LOSS_COUNT_EN
        .lock_loss_cnt(lock_loss_cnt),
`endif
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: phase number (0 reset-pll .. 4 fail) and clocks dwelt in that phase.
    int m_phase = 0;
    int m_dwell = 0;
    int m_tries = 0;
    int m_loss  = 0;
    bit m_s1 = 1'b0, m_s2 = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit seen;
        int nxt;
        if (rst) begin
            m_phase = 0; m_dwell = 0; m_tries = 0; m_loss = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            seen    = m_s2;
            m_s2    = m_s1;
            m_s1    = pll_locked;
            m_dwell = m_dwell + 1;
            nxt     = m_phase;
            if (restart) begin
                nxt = 0;
                m_tries = 0;
            end else begin
                case (m_phase)
                    0: if (m_dwell == ARST) nxt = 1;
                    1: if (seen) nxt = 2;
                       else if (m_dwell == TMO) begin
                           if (m_tries == MAXR) nxt = 4;
                           else begin m_tries = m_tries + 1; nxt = 0; end
                       end
                    2: if (!seen) nxt = 1; else if (m_dwell == STAB) nxt = 3;
                    3: if (!seen) begin nxt = 0; if (m_loss < 255) m_loss = m_loss + 1; end
                    default: nxt = m_phase;
                endcase
            end
            if (nxt == 3) m_tries = 0;
            if (nxt != m_phase || restart) m_dwell = 0;
            m_phase = nxt;
        end
    end

    always @(negedge clk) begin
        chk("cmp_areset", int'(pll_areset), int'(m_phase == 0 || m_phase == 4));
        chk("cmp_sys_rst", int'(sys_rst), int'(m_phase != 3));
        chk("cmp_ready", int'(ready), int'(m_phase == 3));
        chk("cmp_fail", int'(fail), int'(m_phase == 4));
        chk("cmp_retry", int'(retry_cnt), m_tries);
        chk("cmp_state", int'(state_o), m_phase);
`ifdef LOCK_LOSS_COUNT_EN
        chk("cmp_loss", int'(lock_loss_cnt), m_loss);
`endif
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, n_ar, n_rdy, falls, lo;
        bit prev, saw_wait, early_rel;

        rst = 1'b1; pll_locked = 1'b0; restart = 1'b0;
        step(); step();
        chk("reset_areset", int'(pll_areset), 1);
        chk("reset_sys_rst", int'(sys_rst), 1);
        chk("reset_ready", int'(ready), 0);
        chk("reset_fail", int'(fail), 0);
        chk("reset_retry", int'(retry_cnt), 0);
        chk("reset_state", int'(state_o), 0);

        // Nominal lock
        rst = 1'b0;
        n = 0;
        do begin step(); n++; end while (pll_areset && n < 50);
        chk("nom_areset_len", n, 4);
        step(); step(); step();
        pll_locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (sys_rst && n < 100);
        chk("nom_release_lat", n, 11);
        chk("nom_ready", int'(ready), 1);
        chk("nom_retry", int'(retry_cnt), 0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        n = 0;
        do begin step(); n++; end while (!sys_rst && n < 50);
        chk("loss_sys_rst_lat", n, 3);
        chk("loss_ready", int'(ready), 0);
        chk("loss_areset", int'(pll_areset), 1);
        n = 0;
        do begin step(); n++; end while (pll_areset && n < 50);
        chk("loss_areset_len", n, 4);
`ifdef LOCK_LOSS_COUNT_EN
        chk("loss_count", int'(lock_loss_cnt), 1);
`endif

        // Glitch in STABLE at count 5
        pll_locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (state_o != 3'd2 && n < 50);
        chk("glitch_in_stable", int'(state_o), 2);
        repeat (5) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        n = 0; saw_wait = 1'b0; early_rel = 1'b0;
        do begin
            step(); n++;
            if (state_o == 3'd1) saw_wait = 1'b1;
            if (!sys_rst && state_o != 3'd3) early_rel = 1'b1;
        end while (!ready && n < 100);
        chk("glitch_saw_wait", int'(saw_wait), 1);
        chk("glitch_no_early_rel", int'(early_rel), 0);
        chk("glitch_run_lat", n, 11);
        chk("glitch_retry", int'(retry_cnt), 0);

        // Restart from RUN, then PLL never locks
        restart = 1'b1; pll_locked = 1'b0;
        step();
        restart = 1'b0;
        chk("rst_run_state", int'(state_o), 0);
        chk("rst_run_ready", int'(ready), 0);
        n = 0; falls = 0; lo = 0; prev = pll_areset;
        do begin
            step(); n++;
            if (prev && !pll_areset) falls++;
            if (!pll_areset) lo++;
            prev = pll_areset;
        end while (!fail && n < 200);
        chk("nolock_fail_time", n, 72);
        chk("nolock_pulses", falls, 3);
        chk("nolock_low_clocks", lo, 60);
        chk("nolock_areset", int'(pll_areset), 1);
        chk("nolock_retry", int'(retry_cnt), 2);
        chk("nolock_state", int'(state_o), 4);

        // FAIL is sticky even with lock present
        pll_locked = 1'b1;
        repeat (6) step();
        chk("fail_sticky", int'(state_o), 4);

        // Restart from FAIL
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("fail_restart_fail", int'(fail), 0);
        chk("fail_restart_state", int'(state_o), 0);
        chk("fail_restart_retry", int'(retry_cnt), 0);
        n = 0;
        do begin step(); n++; end while (!ready && n < 100);
        chk("fail_restart_run_lat", n, 13);
`ifdef LOCK_LOSS_COUNT_EN
        chk("loss_kept_by_restart", int'(lock_loss_cnt), 1);
`endif

        // Async reset mid-RUN
        #2 rst = 1'b1;
        #1;
        chk("arst_sys_rst", int'(sys_rst), 1);
        chk("arst_areset", int'(pll_areset), 1);
        chk("arst_ready", int'(ready), 0);
        step();
        rst = 1'b0;
        n = 0; n_ar = 0; n_rdy = 0;
        do begin
            step(); n++;
            if (!pll_areset && n_ar == 0) n_ar = n;
            if (ready) n_rdy = n;
        end while (!ready && n < 100);
        chk("arst_areset_len", n_ar, 4);
        chk("arst_run_lat", n_rdy, 13);
`ifdef LOCK_LOSS_COUNT_EN
        chk("loss_cleared_by_rst", int'(lock_loss_cnt), 0);
`endif

        // Restart during RESET_PLL restarts the pulse count
        restart = 1'b1; step(); restart = 1'b0;
        step(); step();
        restart = 1'b1; step(); restart = 1'b0;
        n = 0;
        do begin step(); n++; end while (pll_areset && n < 50);
        chk("restart_in_reset_len", n, 4);

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Power-up and recovery sequencer for the clock PLL that generates nCLK, BCLK and BBCLK.
- Runs on the free-running CPU reference clock.
- Drives the PLL's asynchronous reset and watches its lock output.
- Holds the system reset asserted until lock has been stable for a programmed time, then releases it. Re-sequences the PLL on lock loss or lock timeout, and latches a fail flag after too many retries.

Parameters:
- ARST_CYCLES, 16: clocks pll_areset is held high per attempt (min 1).
- LOCK_TIMEOUT, 50000: clocks to wait for lock before retrying (min 1).
- STABLE_CYCLES, 1024: consecutive locked clocks required before releasing sys_rst (min 1).
- MAX_RETRY, 3: retries allowed after the first attempt before FAIL (0..15).
- CNT_W, 16: shared counter width; must hold max(ARST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- CPUCLK_I  in  1  reference clock, free-running, never gated.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock status, asynchronous to CPUCLK_I.
- restart  in  1  single-cycle restart request from the control register.
- pll_areset  out  1  PLL reset, active-high.
- sys_rst  out  1  system reset to logic on PLL clocks, active-high.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  4  retries consumed in the current sequence.
- state_o  out  3  encoded state: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL.

Behaviour:
- Reset values (while rst is high): state RESET_PLL, counter 0, pll_areset 1, sys_rst 1, ready 0, fail 0, retry_cnt 0, sync flops 0.
- Output timing: all outputs registered; each is decoded from the next state so that it changes on the same edge as the state.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser to give locked_s. Only locked_s is used internally.
- RESET_PLL:
  - pll_areset=1, sys_rst=1.
  - Counter increments each clock.
  - When the count reaches ARST_CYCLES-1: go to WAIT_LOCK and clear the counter.
  - Net effect: pll_areset is high for exactly ARST_CYCLES clocks.
- WAIT_LOCK:
  - pll_areset=0, sys_rst=1.
  - If locked_s=1: go to STABLE and clear the counter.
  - Else, when the count reaches LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRY, go to FAIL;
    - otherwise increment retry_cnt and go to RESET_PLL.
- STABLE:
  - sys_rst=1.
  - If locked_s=0: go to WAIT_LOCK, clear the counter, leave retry_cnt unchanged.
  - When the count reaches STABLE_CYCLES-1 with locked_s still 1: go to RUN.
- RUN:
  - sys_rst=0, ready=1, retry_cnt cleared on entry.
  - If locked_s=0: go to RESET_PLL. sys_rst rises on that same edge.
- FAIL:
  - pll_areset=1, sys_rst=1, fail=1.
  - Sticky: left only via rst or restart.
- restart:
  - In any state, restart=1 sends the state to RESET_PLL and clears the counter and retry_cnt.
  - Restart has priority over every other transition in that cycle.
  - restart during RESET_PLL restarts the ARST_CYCLES count.
- Release latency: from a pll_locked rise (held high) to the sys_rst fall is exactly STABLE_CYCLES+3 clocks (2 sync, 1 WAIT_LOCK→STABLE, STABLE_CYCLES counting).
- Simultaneous events: locked_s rising on the same cycle the WAIT_LOCK timeout expires counts as lock (go to STABLE).
- Counter: never wraps; it is cleared on every state change.
- Reset mid-operation: rst asserted in any state forces the reset values immediately, asynchronously.

Optional Feature:
- Macro: LOCK_LOSS_COUNT_EN.
- Defined:
  - Adds output lock_loss_cnt, 8 bits, reset 0.
  - Increments on each RUN→RESET_PLL transition caused by loss of lock; saturates at 255.
  - Cleared only by rst; restart does not clear it.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Nominal lock. Params ARST 4, TIMEOUT 20, STABLE 8. Release rst, raise pll_locked 3 clocks after pll_areset falls.
  → pll_areset high exactly 4 clocks; sys_rst falls 11 clocks after the pll_locked rise; ready=1; retry_cnt=0.
- Never locks. Params as above, MAX_RETRY 2, pll_locked held 0.
  → 3 pll_areset pulses of 4 clocks, each separated by 20 clocks low; FAIL entered 72 clocks after rst release; fail=1, pll_areset=1, retry_cnt=2.
- Glitch in STABLE. Lock, then drop pll_locked for 1 clock at STABLE count 5.
  → return to WAIT_LOCK; sys_rst stays 1; retry_cnt unchanged; full 8-clock STABLE count required again after lock returns.
- Lock loss in RUN. Drop pll_locked while in RUN.
  → sys_rst rises 3 clocks after the pll_locked fall; pll_areset high 4 clocks; ready=0. With LOCK_LOSS_COUNT_EN, lock_loss_cnt=1.
- Restart from FAIL. Pulse restart in FAIL, then supply lock.
  → fail=0 and state RESET_PLL on the next edge; retry_cnt=0; normal release follows.
- Async reset in RUN. Assert rst mid-RUN.
  → sys_rst=1, pll_areset=1, ready=0 with no clock edge; on release, the ARST_CYCLES sequence runs again.
